fractal_pixel_scheduler: RTL and testbench
==========================================

Name: fractal_pixel_scheduler

Overview:
Sequences one frame of fractal pixel computation across N_ENG parallel iteration engines and delivers the results in raster order to the stream packer.
- Walks (x,y) over the configured frame size and issues coordinates round-robin to the engines.
- Retires engine results in the same round-robin order, tags them with sof/eol and presents them on a valid/ready pixel interface.
- Sits between the AXI-Lite register file (size/start) and the packer, replacing the free-running x/y counter.

Parameters:
N_ENG, 4, number of iteration engines (power of two, 2..8)
X_W, 10, x coordinate / frame width bits
Y_W, 9, y coordinate / frame height bits
ITER_W, 8, iteration-count result bits

Ports:
out_stream_aclk  in  1  clock
periph_resetn  in  1  asynchronous active-low reset
cfg_x_size  in  X_W  frame width in pixels
cfg_y_size  in  Y_W  frame height in pixels
cfg_start  in  1  one-cycle start pulse
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse at end of frame
eng_req_valid  out  N_ENG  per-engine request strobe, one-hot or zero
eng_req_ready  in  N_ENG  engine idle/accepting
eng_req_x  out  X_W  shared request x
eng_req_y  out  Y_W  shared request y
eng_res_valid  in  N_ENG  per-engine result valid
eng_res_iter  in  N_ENG*ITER_W  packed results; engine i at [i*ITER_W +: ITER_W]
eng_res_ready  out  N_ENG  per-engine result accept, one-hot or zero
pix_valid  out  1  output pixel valid
pix_ready  in  1  packer ready
pix_iter  out  ITER_W  iteration count
pix_sof  out  1  first pixel of frame (x=0,y=0)
pix_eol  out  1  last pixel of line

Behaviour:
Reset (async assert, sync release):
- State IDLE; all pointers and counters 0.
- busy=0, frame_done=0, eng_req_valid=0, eng_res_ready=0, pix_valid=0, pix_sof=0, pix_eol=0, pix_iter=0.

State machine IDLE -> RUN -> DRAIN -> IDLE:
- IDLE: on cfg_start, latch both sizes into xs/ys.
  - If either size is 0: stay IDLE, pulse frame_done the next cycle.
  - Otherwise go RUN and set busy=1.
  - cfg_start is ignored when not in IDLE. Configuration changes mid-frame have no effect.
- RUN: issue side active. When the last coordinate (xs-1, ys-1) is issued, go DRAIN.
- DRAIN: no new issues. When the output handshake completes on the last pixel, pulse frame_done, clear busy, go IDLE.

Issue side:
- Pointer iss_ptr (log2 N_ENG bits) and coordinates ix/iy.
- eng_req_valid[iss_ptr] = (state==RUN) && eng_req_ready[iss_ptr] && (credit[iss_ptr]==0). This is combinational; eng_req_x/y = ix/iy.
- On each issue:
  - set credit[iss_ptr];
  - iss_ptr wraps mod N_ENG;
  - ix increments and wraps to 0 at xs-1, where iy increments.
- Maximum issue rate is one per cycle. At most one outstanding request per engine.

Retire side:
- Pointer ret_ptr and coordinates rx/ry.
- eng_res_ready[ret_ptr] = credit[ret_ptr] && (!pix_valid || pix_ready).
- On eng_res_valid[ret_ptr] && eng_res_ready[ret_ptr], in the same edge:
  - load the output register: pix_iter = result, pix_sof = (rx==0 && ry==0), pix_eol = (rx==xs-1);
  - set pix_valid=1; clear credit[ret_ptr];
  - advance ret_ptr, rx, ry (same wrap rules as the issue side).
- Results from engines other than ret_ptr are held by that engine until their turn; raster order is guaranteed.

Simultaneous events and stalls:
- Issue and retire on the same engine in the same cycle: the credit clear wins first, so a new issue to that engine is allowed the following cycle, never the same cycle.
- pix_valid && !pix_ready holds pix_* stable and deasserts all eng_res_ready.
- Output register gives one-cycle latency from result handshake to pix_valid. Full throughput is one pixel per cycle.

Boundary cases:
- 1x1 frame: the single pixel has both sof and eol set.
- Reset mid-frame: all state is discarded immediately. Engines must also be reset by periph_resetn.

Decomposition:
Shared package fractal_pkg holds:
- the state enum (IDLE/RUN/DRAIN);
- default widths X_W, Y_W, ITER_W;
- the raster-advance constants.

One sub-module, raster_counter (x/y counter with wrap, last_x, last_frame outputs), is instantiated twice: once for issue and once for retire.

Test Plan:
- 4x2 frame, N_ENG=4, engines answer after 3 cycles, pix_ready=1 -> 8 pixels in raster order; sof on pixel 0; eol on pixels 3 and 7; frame_done pulses one cycle after the last handshake; busy then drops.
- Engine latencies 10/2/7/1 cycles (out-of-order completion), 8x1 frame -> output still x=0..7 in order; iter values match engine-returned tags equal to x.
- pix_ready toggled 1,0,0,1 repeatedly on a 5x3 frame -> no pixel lost or duplicated; pix_* stable while stalled; 15 pixels total.
- cfg_start with cfg_x_size=0 -> no eng_req_valid; busy stays 0; frame_done pulses exactly once. Separately, a 1x1 frame -> one pixel with sof=eol=1.
- cfg_start reasserted mid-frame with different sizes -> ignored; current frame completes with the original size.
- periph_resetn asserted after 5 pixels of a 640x480 frame -> all outputs 0 asynchronously; a restart produces sof on the first pixel at (0,0).

Source files
------------

// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal pixel scheduler: scheduler states,
// default bus widths and the constants used when stepping through a raster.
package fractal_pkg;

   // Default coordinate and result widths
   localparam int unsigned DEF_X_W    = 10;
   localparam int unsigned DEF_Y_W    = 9;
   localparam int unsigned DEF_ITER_W = 8;

   // Raster-advance constants: where a line/frame restarts and the step size
   localparam int unsigned RASTER_ORIGIN = 0;
   localparam int unsigned RASTER_STEP   = 1;

   // Frame sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_e;

endpackage

// File: rtl/fractal_pixel_scheduler_if.sv
// Pixel stream between the scheduler (master) and the stream packer (slave).
interface fractal_pixel_scheduler_if
   import fractal_pkg::*;
#(
   parameter int unsigned ITER_W = DEF_ITER_W
);

   logic              pix_valid;
   logic              pix_ready;
   logic [ITER_W-1:0] pix_iter;
   logic              pix_sof;
   logic              pix_eol;

   modport master (
      output pix_valid,
      output pix_iter,
      output pix_sof,
      output pix_eol,
      input  pix_ready
   );

   modport slave (
      input  pix_valid,
      input  pix_iter,
      input  pix_sof,
      input  pix_eol,
      output pix_ready
   );

endinterface

// File: rtl/raster_counter.sv
// Raster x/y walker: x runs 0..xs-1, wrapping into the next line, and the
// whole frame wraps back to the origin after (xs-1, ys-1).
module raster_counter
   import fractal_pkg::*;
#(
   parameter int unsigned X_W = DEF_X_W,
   parameter int unsigned Y_W = DEF_Y_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           adv,
   input  logic [X_W-1:0] xs,
   input  logic [Y_W-1:0] ys,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last_x,
   output logic           last_frame
);

   logic [X_W-1:0] x_r;
   logic [Y_W-1:0] y_r;
   logic           last_x_s;
   logic           last_y_s;

   // End-of-line / end-of-frame decode against the latched frame size
   always_comb begin
      last_x_s = (x_r == (xs - X_W'(RASTER_STEP)));
      last_y_s = (y_r == (ys - Y_W'(RASTER_STEP)));
   end

   // Coordinate registers: restart on clr, step on adv
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r <= X_W'(RASTER_ORIGIN);
         y_r <= Y_W'(RASTER_ORIGIN);
      end else if (clr) begin
         x_r <= X_W'(RASTER_ORIGIN);
         y_r <= Y_W'(RASTER_ORIGIN);
      end else if (adv) begin
         if (last_x_s) begin
            x_r <= X_W'(RASTER_ORIGIN);
            if (last_y_s) begin
               y_r <= Y_W'(RASTER_ORIGIN);
            end else begin
               y_r <= y_r + Y_W'(RASTER_STEP);
            end
         end else begin
            x_r <= x_r + X_W'(RASTER_STEP);
         end
      end else begin
         x_r <= x_r;
         y_r <= y_r;
      end
   end

   assign x          = x_r;
   assign y          = y_r;
   assign last_x     = last_x_s;
   assign last_frame = last_x_s && last_y_s;

endmodule

// File: rtl/fractal_pixel_scheduler.sv
// Frame sequencer for N_ENG iteration engines. Coordinates are issued
// round-robin, results are retired in the same round-robin order, so pixels
// leave in raster order regardless of engine completion order. A per-engine
// credit bit limits each engine to one outstanding request.
module fractal_pixel_scheduler
   import fractal_pkg::*;
#(
   parameter int unsigned N_ENG  = 4,
   parameter int unsigned X_W    = DEF_X_W,
   parameter int unsigned Y_W    = DEF_Y_W,
   parameter int unsigned ITER_W = DEF_ITER_W
) (
   input  logic                    out_stream_aclk,
   input  logic                    periph_resetn,
   input  logic [X_W-1:0]          cfg_x_size,
   input  logic [Y_W-1:0]          cfg_y_size,
   input  logic                    cfg_start,
   output logic                    busy,
   output logic                    frame_done,
   output logic [N_ENG-1:0]        eng_req_valid,
   input  logic [N_ENG-1:0]        eng_req_ready,
   output logic [X_W-1:0]          eng_req_x,
   output logic [Y_W-1:0]          eng_req_y,
   input  logic [N_ENG-1:0]        eng_res_valid,
   input  logic [N_ENG*ITER_W-1:0] eng_res_iter,
   output logic [N_ENG-1:0]        eng_res_ready,
   fractal_pixel_scheduler_if.master pix
);

   localparam int unsigned PTR_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;
   localparam logic [N_ENG-1:0] ENG_ONE = {{(N_ENG-1){1'b0}}, 1'b1};

   sched_state_e      state_r;
   logic [X_W-1:0]    xs_r;
   logic [Y_W-1:0]    ys_r;
   logic              busy_r;
   logic              frame_done_r;
   logic [N_ENG-1:0]  credit_r;
   logic [PTR_W-1:0]  iss_ptr_r;
   logic [PTR_W-1:0]  ret_ptr_r;
   logic              pix_valid_r;
   logic [ITER_W-1:0] pix_iter_r;
   logic              pix_sof_r;
   logic              pix_eol_r;
   logic              last_pix_r;

   logic              start_s;
   logic              start_zero_s;
   logic              issue_fire_s;
   logic              ret_ready_s;
   logic              ret_fire_s;
   logic              out_hs_s;
   logic [N_ENG-1:0]  iss_sel_s;
   logic [N_ENG-1:0]  ret_sel_s;
   logic [N_ENG-1:0]  credit_nxt_s;
   logic [ITER_W-1:0] ret_iter_s;
   logic              iss_done_s;

   logic [X_W-1:0]    iss_x_s;
   logic [Y_W-1:0]    iss_y_s;
   logic              iss_last_x_s;
   logic              iss_last_frame_s;
   logic [X_W-1:0]    ret_x_s;
   logic [Y_W-1:0]    ret_y_s;
   logic              ret_last_x_s;
   logic              ret_last_frame_s;

   // Issue-side raster walker
   raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_iss_cnt (
      .clk        (out_stream_aclk),
      .rst_n      (periph_resetn),
      .clr        (start_s),
      .adv        (issue_fire_s),
      .xs         (xs_r),
      .ys         (ys_r),
      .x          (iss_x_s),
      .y          (iss_y_s),
      .last_x     (iss_last_x_s),
      .last_frame (iss_last_frame_s)
   );

   // Retire-side raster walker, tracks the coordinate of the next output pixel
   raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_ret_cnt (
      .clk        (out_stream_aclk),
      .rst_n      (periph_resetn),
      .clr        (start_s),
      .adv        (ret_fire_s),
      .xs         (xs_r),
      .ys         (ys_r),
      .x          (ret_x_s),
      .y          (ret_y_s),
      .last_x     (ret_last_x_s),
      .last_frame (ret_last_frame_s)
   );

   // Handshake decode: issue/retire strobes, credit update and result select
   always_comb begin
      start_s      = (state_r == ST_IDLE) && cfg_start;
      start_zero_s = (cfg_x_size == {X_W{1'b0}}) || (cfg_y_size == {Y_W{1'b0}});
      iss_sel_s    = ENG_ONE << iss_ptr_r;
      ret_sel_s    = ENG_ONE << ret_ptr_r;
      iss_done_s   = iss_last_x_s && iss_last_frame_s;
      out_hs_s     = pix_valid_r && pix.pix_ready;
      ret_iter_s   = eng_res_iter[ret_ptr_r*ITER_W +: ITER_W];

      if (state_r == ST_RUN) begin
         issue_fire_s = eng_req_ready[iss_ptr_r] && !credit_r[iss_ptr_r];
      end else begin
         issue_fire_s = 1'b0;
      end

      // A stalled output register blocks all retirement
      if (credit_r[ret_ptr_r] && (!pix_valid_r || pix.pix_ready)) begin
         ret_ready_s = 1'b1;
      end else begin
         ret_ready_s = 1'b0;
      end
      ret_fire_s = ret_ready_s && eng_res_valid[ret_ptr_r];

      credit_nxt_s = credit_r;
      if (ret_fire_s) begin
         credit_nxt_s = credit_nxt_s & ~ret_sel_s;
      end else begin
         credit_nxt_s = credit_nxt_s;
      end
      if (issue_fire_s) begin
         credit_nxt_s = credit_nxt_s | iss_sel_s;
      end else begin
         credit_nxt_s = credit_nxt_s;
      end

      eng_req_valid = issue_fire_s ? iss_sel_s : {N_ENG{1'b0}};
      eng_res_ready = ret_ready_s  ? ret_sel_s : {N_ENG{1'b0}};
   end

   // Frame sequencer: start acceptance, RUN->DRAIN on last issue, done on last output
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         state_r      <= ST_IDLE;
         xs_r         <= {X_W{1'b0}};
         ys_r         <= {Y_W{1'b0}};
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cfg_start) begin
                  xs_r <= cfg_x_size;
                  ys_r <= cfg_y_size;
                  if (start_zero_s) begin
                     frame_done_r <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                     busy_r  <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (issue_fire_s && iss_done_s) begin
                  state_r <= ST_DRAIN;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (out_hs_s && last_pix_r) begin
                  frame_done_r <= 1'b1;
                  busy_r       <= 1'b0;
                  state_r      <= ST_IDLE;
               end else begin
                  state_r <= ST_DRAIN;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Round-robin pointers and per-engine outstanding-request credits
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         credit_r  <= {N_ENG{1'b0}};
         iss_ptr_r <= {PTR_W{1'b0}};
         ret_ptr_r <= {PTR_W{1'b0}};
      end else if (start_s) begin
         credit_r  <= {N_ENG{1'b0}};
         iss_ptr_r <= {PTR_W{1'b0}};
         ret_ptr_r <= {PTR_W{1'b0}};
      end else begin
         credit_r <= credit_nxt_s;
         if (issue_fire_s) begin
            iss_ptr_r <= iss_ptr_r + PTR_W'(1);
         end else begin
            iss_ptr_r <= iss_ptr_r;
         end
         if (ret_fire_s) begin
            ret_ptr_r <= ret_ptr_r + PTR_W'(1);
         end else begin
            ret_ptr_r <= ret_ptr_r;
         end
      end
   end

   // Output pixel register: loads on retire, empties on downstream accept
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         pix_valid_r <= 1'b0;
         pix_iter_r  <= {ITER_W{1'b0}};
         pix_sof_r   <= 1'b0;
         pix_eol_r   <= 1'b0;
         last_pix_r  <= 1'b0;
      end else if (ret_fire_s) begin
         pix_valid_r <= 1'b1;
         pix_iter_r  <= ret_iter_s;
         pix_sof_r   <= (ret_x_s == {X_W{1'b0}}) && (ret_y_s == {Y_W{1'b0}});
         pix_eol_r   <= ret_last_x_s;
         last_pix_r  <= ret_last_frame_s;
      end else if (out_hs_s) begin
         pix_valid_r <= 1'b0;
      end else begin
         pix_valid_r <= pix_valid_r;
      end
   end

   assign busy          = busy_r;
   assign frame_done    = frame_done_r;
   assign eng_req_x     = iss_x_s;
   assign eng_req_y     = iss_y_s;
   assign pix.pix_valid = pix_valid_r;
   assign pix.pix_iter  = pix_iter_r;
   assign pix.pix_sof   = pix_sof_r;
   assign pix.pix_eol   = pix_eol_r;

endmodule

// File: tb/tb_fractal_pixel_scheduler.sv
// Directed bench for fractal_pixel_scheduler: behavioural engines with
// programmable latency answer each request with tag = x + 16*y; a monitor
// checks raster order, sof/eol, stall stability and frame_done timing.
module tb_fractal_pixel_scheduler;

   localparam int N_ENG  = 4;
   localparam int X_W    = 10;
   localparam int Y_W    = 9;
   localparam int ITER_W = 8;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [X_W-1:0]          cfg_x_size;
   logic [Y_W-1:0]          cfg_y_size;
   logic                    cfg_start;
   logic                    busy;
   logic                    frame_done;
   logic [N_ENG-1:0]        eng_req_valid;
   logic [N_ENG-1:0]        eng_req_ready;
   logic [X_W-1:0]          eng_req_x;
   logic [Y_W-1:0]          eng_req_y;
   logic [N_ENG-1:0]        eng_res_valid;
   logic [N_ENG*ITER_W-1:0] eng_res_iter;
   logic [N_ENG-1:0]        eng_res_ready;

   fractal_pixel_scheduler_if #(.ITER_W(ITER_W)) pix_bus ();

   fractal_pixel_scheduler #(
      .N_ENG(N_ENG), .X_W(X_W), .Y_W(Y_W), .ITER_W(ITER_W)
   ) dut (
      .out_stream_aclk (clk),
      .periph_resetn   (rst_n),
      .cfg_x_size      (cfg_x_size),
      .cfg_y_size      (cfg_y_size),
      .cfg_start       (cfg_start),
      .busy            (busy),
      .frame_done      (frame_done),
      .eng_req_valid   (eng_req_valid),
      .eng_req_ready   (eng_req_ready),
      .eng_req_x       (eng_req_x),
      .eng_req_y       (eng_req_y),
      .eng_res_valid   (eng_res_valid),
      .eng_res_iter    (eng_res_iter),
      .eng_res_ready   (eng_res_ready),
      .pix             (pix_bus.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // expected-model state
   int fx, fy;
   int ex, ey, ix, iy, ip;
   int pix_cnt  = 0;
   int done_cnt = 0;
   int cyc      = 0;
   int rdy_mode = 0;
   int lat [N_ENG];
   bit exp_done_next = 1'b0;
   bit held          = 1'b0;
   bit chk_no_req    = 1'b0;
   logic [ITER_W-1:0] h_iter;
   logic              h_sof, h_eol;

   // engine model state
   bit                e_busy [N_ENG];
   int                e_cnt  [N_ENG];
   logic [ITER_W-1:0] e_tag  [N_ENG];
   logic [N_ENG-1:0]  hs_req, hs_res;
   logic [X_W-1:0]    cap_x;
   logic [Y_W-1:0]    cap_y;
   logic [N_ENG-1:0]  exp_sel;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [ITER_W-1:0] tag_of(input int x, input int y);
      return ITER_W'(x + 16 * y);
   endfunction

   task automatic check_idle_outputs(input string pfx);
      check_eq({pfx, "_busy"},       32'(busy),               32'd0);
      check_eq({pfx, "_frame_done"}, 32'(frame_done),         32'd0);
      check_eq({pfx, "_req_valid"},  32'(eng_req_valid),      32'd0);
      check_eq({pfx, "_res_ready"},  32'(eng_res_ready),      32'd0);
      check_eq({pfx, "_pix_valid"},  32'(pix_bus.pix_valid),  32'd0);
      check_eq({pfx, "_pix_sof"},    32'(pix_bus.pix_sof),    32'd0);
      check_eq({pfx, "_pix_eol"},    32'(pix_bus.pix_eol),    32'd0);
      check_eq({pfx, "_pix_iter"},   32'(pix_bus.pix_iter),   32'd0);
   endtask

   // Engines: capture handshakes away from the edge, update drives after it
   initial begin
      for (int i = 0; i < N_ENG; i++) begin
         e_busy[i] = 1'b0; e_cnt[i] = 0; e_tag[i] = '0;
      end
      eng_req_ready     = '1;
      eng_res_valid     = '0;
      eng_res_iter      = '0;
      pix_bus.pix_ready = 1'b1;
      forever begin
         @(negedge clk);
         hs_req = eng_req_valid & eng_req_ready;
         hs_res = eng_res_valid & eng_res_ready;
         cap_x  = eng_req_x;
         cap_y  = eng_req_y;
         if (hs_req != '0) begin
            exp_sel = 4'b0001 << ip;
            check_eq("req_engine", 32'(hs_req), 32'(exp_sel));
            check_eq("req_x", 32'(cap_x), 32'(ix));
            check_eq("req_y", 32'(cap_y), 32'(iy));
            ip = (ip + 1) % N_ENG;
            ix = ix + 1;
            if (ix == fx) begin
               ix = 0;
               iy = iy + 1;
               if (iy == fy) iy = 0;
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < N_ENG; i++) begin
            if (!rst_n) begin
               e_busy[i] = 1'b0;
               eng_res_valid[i] = 1'b0;
            end else begin
               if (hs_res[i]) begin
                  e_busy[i] = 1'b0;
                  eng_res_valid[i] = 1'b0;
               end
               if (hs_req[i]) begin
                  e_busy[i] = 1'b1;
                  e_cnt[i]  = lat[i];
                  e_tag[i]  = tag_of(int'(cap_x), int'(cap_y));
               end else if (e_busy[i] && !eng_res_valid[i]) begin
                  if (e_cnt[i] <= 1) eng_res_valid[i] = 1'b1;
                  else e_cnt[i] = e_cnt[i] - 1;
               end
            end
            eng_req_ready[i] = !e_busy[i];
            eng_res_iter[i*ITER_W +: ITER_W] = e_tag[i];
         end
         if (rdy_mode == 0) pix_bus.pix_ready = 1'b1;
         else pix_bus.pix_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      end
   end

   // Output monitor: raster order, tags, sof/eol, stalls, frame_done timing
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 1'b0;
            exp_done_next = 1'b0;
         end else begin
            if (frame_done) done_cnt++;
            if (exp_done_next) begin
               check_eq("done_after_last", 32'(frame_done), 32'd1);
               check_eq("busy_after_done", 32'(busy), 32'd0);
               exp_done_next = 1'b0;
            end
            if (held) begin
               check_eq("stall_valid", 32'(pix_bus.pix_valid), 32'd1);
               check_eq("stall_iter",  32'(pix_bus.pix_iter),  32'(h_iter));
               check_eq("stall_sof",   32'(pix_bus.pix_sof),   32'(h_sof));
               check_eq("stall_eol",   32'(pix_bus.pix_eol),   32'(h_eol));
            end
            if (chk_no_req) check_eq("zero_no_req", 32'(eng_req_valid), 32'd0);
            if (pix_bus.pix_valid && pix_bus.pix_ready) begin
               check_eq("pix_iter", 32'(pix_bus.pix_iter), 32'(tag_of(ex, ey)));
               check_eq("pix_sof",  32'(pix_bus.pix_sof),  32'((ex == 0) && (ey == 0)));
               check_eq("pix_eol",  32'(pix_bus.pix_eol),  32'(ex == fx - 1));
               pix_cnt++;
               if ((ex == fx - 1) && (ey == fy - 1)) exp_done_next = 1'b1;
               ex = ex + 1;
               if (ex == fx) begin
                  ex = 0;
                  ey = ey + 1;
                  if (ey == fy) ey = 0;
               end
               held = 1'b0;
            end else begin
               held   = pix_bus.pix_valid;
               h_iter = pix_bus.pix_iter;
               h_sof  = pix_bus.pix_sof;
               h_eol  = pix_bus.pix_eol;
            end
         end
      end
   end

   task automatic setup_frame(input int xs, input int ys, input int l0, input int l1,
                              input int l2, input int l3, input int rmode);
      fx = xs; fy = ys;
      ex = 0; ey = 0; ix = 0; iy = 0; ip = 0;
      pix_cnt = 0;
      lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
      rdy_mode = rmode;
   endtask

   task automatic pulse_start(input int xs, input int ys);
      @(posedge clk); #1;
      cfg_x_size = X_W'(xs);
      cfg_y_size = Y_W'(ys);
      cfg_start  = 1'b1;
      @(posedge clk); #1;
      cfg_start  = 1'b0;
   endtask

   task automatic run_frame(input int xs, input int ys, input int l0, input int l1,
                            input int l2, input int l3, input int rmode, input int restart_at);
      int d0;
      bit seen;
      setup_frame(xs, ys, l0, l1, l2, l3, rmode);
      d0 = done_cnt;
      seen = 1'b0;
      pulse_start(xs, ys);
      check_eq("busy_on_start", 32'(busy), 32'd1);
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(posedge clk); #2;
         if (n == restart_at) begin
            cfg_x_size = 10'd3;
            cfg_y_size = 9'd3;
            cfg_start  = 1'b1;
         end else begin
            cfg_start  = 1'b0;
         end
         if (done_cnt != d0) seen = 1'b1;
      end
      cfg_start = 1'b0;
      check_eq("frame_done_count", 32'(done_cnt - d0), 32'd1);
      check_eq("pixel_count", 32'(pix_cnt), 32'(xs * ys));
      check_eq("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int d0;
      rst_n      = 1'b0;
      cfg_x_size = '0;
      cfg_y_size = '0;
      cfg_start  = 1'b0;
      setup_frame(1, 1, 3, 3, 3, 3, 0);
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;

      // 4x2, equal latency, always ready
      run_frame(4, 2, 3, 3, 3, 3, 0, -1);
      // 8x1, out-of-order engine completion
      run_frame(8, 1, 10, 2, 7, 1, 0, -1);
      // 5x3 with pix_ready toggling 1,0,0,1
      run_frame(5, 3, 3, 3, 3, 3, 1, -1);

      // zero width: immediate single frame_done, never busy, no requests
      setup_frame(0, 3, 3, 3, 3, 3, 0);
      d0 = done_cnt;
      chk_no_req = 1'b1;
      pulse_start(0, 3);
      check_eq("zero_done_pulse", 32'(frame_done), 32'd1);
      for (int k = 0; k < 8; k++) begin
         check_eq("zero_busy", 32'(busy), 32'd0);
         @(posedge clk); #1;
      end
      chk_no_req = 1'b0;
      check_eq("zero_done_once", 32'(done_cnt - d0), 32'd1);

      // 1x1 frame: single pixel carries both sof and eol
      run_frame(1, 1, 2, 2, 2, 2, 0, -1);

      // start re-pulsed mid-frame with other sizes: ignored
      run_frame(4, 2, 4, 4, 4, 4, 0, 3);

      // reset in the middle of a large frame
      setup_frame(640, 480, 3, 3, 3, 3, 0);
      pulse_start(640, 480);
      for (int n = 0; n < 500 && pix_cnt < 5; n++) begin
         @(posedge clk); #2;
      end
      check_eq("five_pixels_seen", 32'(pix_cnt >= 5), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_frame(2, 2, 3, 3, 3, 3, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
